mem_cell_allocator: RTL and testbench

- Free-list manager for the shared packet cell buffer. Cells are BLOCK_BYTES each, linked through footers.
- Hands out free cell indices to the ingress writer and sets a per-cell reference count for multicast fan-out.
- Takes cells back from the egress readers and returns a cell to the free pool only when its last reference is released.
- Generalises the fixed 64-cell buffer layout to arbitrary depth and adds reference counting, occupancy watermarks and error flags.

---
 rtl/mem_cell_allocator.sv | 126 ++++++++++++
 tb/tb_mem_cell_allocator.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_cell_allocator.sv
// mem_cell_allocator: free-list manager for the shared packet cell buffer with per-cell reference counts.
//
// Ports:
//   i_clk, i_rst_n          clock and asynchronous active-low reset
//   o_init_done             free list fully populated after reset
//   o_alloc_valid/ready     allocation handshake; o_alloc_idx is the head free cell
//   i_alloc_refcnt          fan-out assigned to the cell taken this cycle
//   i_rel_valid, i_rel_idx  release one reference of a cell (no backpressure)
//   o_free_count            cells currently in the free list
//   o_almost_empty          o_free_count <= LOW_WM (registered)
//   o_err_double_free       sticky: release of a cell whose refcount is 0
//   o_err_zero_ref          sticky: allocation with zero fan-out
module mem_cell_allocator #(
    parameter int NUM_BLOCKS = 64,
    parameter int ADDR_W     = $clog2(NUM_BLOCKS),
    parameter int REFCNT_W   = 3,
    parameter int LOW_WM     = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    output logic                o_init_done,
    output logic                o_alloc_valid,
    input  logic                i_alloc_ready,
    output logic [ADDR_W-1:0]   o_alloc_idx,
    input  logic [REFCNT_W-1:0] i_alloc_refcnt,
    input  logic                i_rel_valid,
    input  logic [ADDR_W-1:0]   i_rel_idx,
    output logic [ADDR_W:0]     o_free_count,
    output logic                o_almost_empty,
    output logic                o_err_double_free,
    output logic                o_err_zero_ref
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_fifo   [NUM_BLOCKS];
    logic [REFCNT_W-1:0]   r_refcnt [NUM_BLOCKS];
    logic [ADDR_W-1:0]     r_head, r_tail, w_head_nxt, w_tail_nxt;
    logic [ADDR_W:0]       r_free_count, w_count_nxt;
    logic                  r_almost_empty, r_err_df, r_err_zr;
    logic                  w_init_wr, w_pop, w_push, w_clr, w_dec, w_err_df, w_err_zr;
    logic [REFCNT_W-1:0]   w_rel_cnt;

    assign o_init_done       = (r_state == S_RUN);
    assign o_alloc_valid     = (r_state == S_RUN) && (r_free_count != '0);
    assign o_alloc_idx       = r_fifo[r_head];
    assign o_free_count      = r_free_count;
    assign o_almost_empty    = r_almost_empty;
    assign o_err_double_free = r_err_df;
    assign o_err_zero_ref    = r_err_zr;

    always_comb begin
        w_state_nxt = r_state;
        w_init_wr   = 1'b0;
        w_pop       = 1'b0;
        w_push      = 1'b0;
        w_clr       = 1'b0;
        w_dec       = 1'b0;
        w_err_df    = 1'b0;
        w_err_zr    = 1'b0;
        // Release always looks at the pre-update count, so releasing the cell
        // being allocated this cycle sees 0 and is flagged.
        w_rel_cnt   = r_refcnt[i_rel_idx];
        if (r_state == S_INIT) begin
            // tail doubles as the init counter: slot i receives index i
            w_init_wr = 1'b1;
            if (r_tail == ADDR_W'(NUM_BLOCKS - 1))
                w_state_nxt = S_RUN;
        end else begin
            w_pop    = o_alloc_valid && i_alloc_ready;
            w_err_zr = w_pop && (i_alloc_refcnt == '0);
            if (i_rel_valid) begin
                w_err_df = (w_rel_cnt == '0);
                w_clr    = (w_rel_cnt == REFCNT_W'(1));
                w_dec    = (w_rel_cnt > REFCNT_W'(1));
                // a push into a full list can only follow an earlier error; drop it
                w_push   = w_clr && (r_free_count != (ADDR_W+1)'(NUM_BLOCKS));
            end
        end
        w_head_nxt  = r_head + ADDR_W'(w_pop);
        w_tail_nxt  = r_tail + ADDR_W'(w_push | w_init_wr);
        w_count_nxt = r_free_count + (ADDR_W+1)'(w_push | w_init_wr) - (ADDR_W+1)'(w_pop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_INIT;
            r_head         <= '0;
            r_tail         <= '0;
            r_free_count   <= '0;
            r_almost_empty <= 1'b1;
            r_err_df       <= 1'b0;
            r_err_zr       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_head         <= w_head_nxt;
            r_tail         <= w_tail_nxt;
            r_free_count   <= w_count_nxt;
            r_almost_empty <= (w_count_nxt <= (ADDR_W+1)'(LOW_WM));
            r_err_df       <= r_err_df | w_err_df;
            r_err_zr       <= r_err_zr | w_err_zr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_BLOCKS; i++) r_fifo[i] <= '0;
        end else if (w_init_wr || w_push) begin
            r_fifo[r_tail] <= w_init_wr ? r_tail : i_rel_idx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_BLOCKS; i++) r_refcnt[i] <= '0;
        end else begin
            if (w_clr)
                r_refcnt[i_rel_idx] <= '0;
            if (w_dec)
                r_refcnt[i_rel_idx] <= w_rel_cnt - REFCNT_W'(1);
            // zero fan-out is stored as 1 so a single release frees the cell
            if (w_pop)
                r_refcnt[o_alloc_idx] <= (i_alloc_refcnt == '0) ? REFCNT_W'(1) : i_alloc_refcnt;
        end
    end
endmodule

// File: tb/tb_mem_cell_allocator.sv
// tb_mem_cell_allocator: randomized and directed checks of mem_cell_allocator against a queue-based model.
module tb_mem_cell_allocator;
    localparam int NB = 8;
    localparam int AW = 3;
    localparam int RW = 3;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done, alloc_valid, alloc_ready = 1'b0;
    logic [AW-1:0] alloc_idx;
    logic [RW-1:0] alloc_refcnt = '0;
    logic          rel_valid = 1'b0;
    logic [AW-1:0] rel_idx = '0;
    logic [AW:0]   free_count;
    logic          almost_empty, err_df, err_zr;

    int n_cmp = 0;
    int n_err = 0;
    int m_q[$];
    int m_ref[NB];
    bit m_df, m_zr;

    always #5 clk = ~clk;

    mem_cell_allocator #(.NUM_BLOCKS(NB), .REFCNT_W(RW), .LOW_WM(LW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_init_done(init_done),
        .o_alloc_valid(alloc_valid), .i_alloc_ready(alloc_ready), .o_alloc_idx(alloc_idx),
        .i_alloc_refcnt(alloc_refcnt), .i_rel_valid(rel_valid), .i_rel_idx(rel_idx),
        .o_free_count(free_count), .o_almost_empty(almost_empty),
        .o_err_double_free(err_df), .o_err_zero_ref(err_zr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model.
    task automatic cycle(input bit ar, input int rc, input bit rv, input int ri);
        int cnt, idx;
        bit pop;
        alloc_ready = ar;
        alloc_refcnt = RW'(rc);
        rel_valid = rv;
        rel_idx = AW'(ri);
        #1;
        check("init_done", init_done, 1);
        check("alloc_valid", alloc_valid, m_q.size() != 0);
        if (m_q.size() != 0) check("alloc_idx", alloc_idx, m_q[0]);
        check("free_count", free_count, m_q.size());
        check("almost_empty", almost_empty, m_q.size() <= LW);
        check("err_double_free", err_df, m_df);
        check("err_zero_ref", err_zr, m_zr);
        pop = ar && m_q.size() != 0;
        if (rv) begin
            cnt = m_ref[ri];
            if (cnt == 0) m_df = 1;
            else if (cnt == 1) begin
                m_ref[ri] = 0;
                if (m_q.size() < NB) m_q.push_back(ri);
            end else m_ref[ri] = cnt - 1;
        end
        if (pop) begin
            idx = m_q.pop_front();
            m_ref[idx] = (rc == 0) ? 1 : rc;
            if (rc == 0) m_zr = 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_and_init();
        rst_n = 1'b0;
        alloc_ready = 1'b0;
        rel_valid = 1'b0;
        #2;
        check("rst_init_done", init_done, 0);
        check("rst_alloc_valid", alloc_valid, 0);
        check("rst_alloc_idx", alloc_idx, 0);
        check("rst_free_count", free_count, 0);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_err_df", err_df, 0);
        check("rst_err_zr", err_zr, 0);
        m_q.delete();
        for (int i = 0; i < NB; i++) m_ref[i] = 0;
        m_df = 0;
        m_zr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NB; k++) begin
            alloc_ready = 1'b1;
            rel_valid = 1'b1;
            rel_idx = AW'($urandom_range(0, NB - 1));
            #1;
            check("init_busy", init_done, 0);
            check("init_valid", alloc_valid, 0);
            check("init_count", free_count, k);
            check("init_ae", almost_empty, k <= LW);
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 0; i < NB; i++) m_q.push_back(i);
    endtask

    initial begin
        int ri, h;
        @(negedge clk);
        reset_and_init();
        // multicast: cell 0 with fan-out 3, freed on third release
        cycle(1, 3, 0, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 0);
        // drain everything, including the requeued cell 0 last
        for (int k = 0; k < NB; k++) cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        // refill five cells, then allocate and free cell 2 together
        foreach (m_ref[i]) if (i != 2 && i != 6 && i != 7) cycle(0, 1, 1, i);
        cycle(1, 1, 1, 2);
        // errors: double free of a free cell, zero fan-out allocation
        cycle(0, 1, 1, m_q[0]);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 1, 1);
        // release of the cell being allocated in the same cycle
        h = m_q[0];
        cycle(1, 2, 1, h);
        for (int n = 0; n < 400; n++) begin
            ri = $urandom_range(0, NB - 1);
            if ($urandom_range(0, 9) < 8)
                for (int k = 0; k < NB; k++)
                    if (m_ref[(ri + k) % NB] != 0) begin
                        ri = (ri + k) % NB;
                        break;
                    end
            cycle($urandom_range(0, 2) != 0, ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 7),
                  $urandom_range(0, 1), ri);
        end
        // mid-run reset after three allocations
        for (int k = 0; k < 3; k++) cycle(1, 1, 0, 0);
        reset_and_init();
        for (int n = 0; n < 60; n++) cycle($urandom_range(0, 1), $urandom_range(1, 7), $urandom_range(0, 1),
                                           $urandom_range(0, NB - 1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
